// File: rtl/common.sv
// Shared type and constant package for the commit path.
// Provides thread/address/data typedefs, the TLB-write selector enum, the
// store-queue entry layout and default parameter values.
package common;
  localparam int          N_THREADS_DEFAULT  = 8;
  localparam int          STQ_DEPTH_DEFAULT  = 4;
  localparam logic [31:0] PC_RESET_DEFAULT   = 32'h1000;
  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h2000;

  typedef logic [$clog2(N_THREADS_DEFAULT)-1:0] threadid_t;
  typedef logic [31:0] word_t;
  typedef logic [31:0] vptr_t;
  typedef logic [31:0] pptr_t;
  typedef logic [4:0]  regid_t;
  typedef logic [19:0] vpn_t;
  typedef logic [7:0]  ppn_t;

  typedef enum logic [1:0] {
    TLBW_NONE = 2'd0,
    TLBW_ITLB = 2'd1,
    TLBW_DTLB = 2'd2
  } tlbwrite_t;

  // One pending store towards the d-cache.
  typedef struct packed {
    vpn_t  addr;
    word_t data;
    logic  isbyte;
  } st_entry_t;
endpackage

// File: rtl/store_queue.sv
// Parametrised FIFO holding committed stores until the d-cache accepts them.
// Ports:
//   clk, rst            clock, synchronous active-high reset (drops contents)
//   enq_en, enq_data    push request; ignored while full
//   deq_ready           consumer accepts head this cycle (effective when count != 0)
//   deq_data            head entry, zero when empty
//   full, count         occupancy, both derived from the registered count
module store_queue #(
  parameter int DEPTH = 4,
  parameter int W     = 53
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enq_en,
  input  logic [W-1:0]             enq_data,
  input  logic                     deq_ready,
  output logic [W-1:0]             deq_data,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   cnt;
  logic          do_enq, do_deq;

  // Full uses the registered count, so a same-cycle dequeue never frees a slot.
  assign full     = (cnt == (AW+1)'(DEPTH));
  assign count    = cnt;
  assign do_enq   = enq_en & ~full;
  assign do_deq   = (cnt != '0) & deq_ready;
  assign deq_data = (cnt != '0) ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_enq) begin
        mem[wr_ptr] <= enq_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_deq) rd_ptr <= rd_ptr + 1'b1;
      case ({do_enq, do_deq})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

// File: rtl/commit_unit.sv
// In-order commit stage for the fine-grained multithreaded core.
// Consumes one TLWB packet per cycle; the packet acts only when its PC matches
// the thread's expected PC. Drives per-thread fetch PC and mode, register-file
// writes, TLB writes, precise TLB-miss exception entry, a ready/valid store
// queue towards the d-cache, and per-thread retired-instruction counters.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   wb_*                     incoming TLWB packet
//   pc, mode                 per-thread fetch PC and supervisor bit
//   rf_wen/thread/addr/data  register-file write pulse
//   st_valid/ready/addr/data/isbyte  store-queue head handshake
//   itlb_wen, dtlb_wen, tlb_vpn, tlb_ppn  TLB write pulse
//   exc_en, exc_thread       exception-entry pulse
//   retired                  per-thread retired-instruction count
module commit_unit import common::*; #(
  parameter int          N_THREADS  = N_THREADS_DEFAULT,
  parameter int          STQ_DEPTH  = STQ_DEPTH_DEFAULT,
  parameter logic [31:0] PC_RESET   = PC_RESET_DEFAULT,
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT,
  localparam int         TW         = $clog2(N_THREADS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [TW-1:0]               wb_thread,
  input  logic                        wb_isvalid,
  input  logic                        wb_itlb_miss,
  input  logic                        wb_dtlb_miss,
  input  logic [31:0]                 wb_pc,
  input  logic [4:0]                  wb_dst,
  input  logic [31:0]                 wb_data,
  input  logic [31:0]                 wb_mul,
  input  logic [31:0]                 wb_r2,
  input  logic                        wb_isequal,
  input  logic                        wb_flag_reg,
  input  logic                        wb_flag_mul,
  input  logic                        wb_flag_jump,
  input  logic                        wb_flag_branch,
  input  logic                        wb_flag_iret,
  input  logic                        wb_flag_store,
  input  logic                        wb_flag_isbyte,
  input  tlbwrite_t                   wb_flag_tlbwrite,
  output logic [N_THREADS-1:0][31:0]  pc,
  output logic [N_THREADS-1:0]        mode,
  output logic                        rf_wen,
  output logic [TW-1:0]               rf_thread,
  output logic [4:0]                  rf_addr,
  output logic [31:0]                 rf_data,
  output logic                        st_valid,
  input  logic                        st_ready,
  output logic [19:0]                 st_addr,
  output logic [31:0]                 st_data,
  output logic                        st_isbyte,
  output logic                        itlb_wen,
  output logic                        dtlb_wen,
  output logic [19:0]                 tlb_vpn,
  output logic [7:0]                  tlb_ppn,
  output logic                        exc_en,
  output logic [TW-1:0]               exc_thread,
  output logic [N_THREADS-1:0][31:0]  retired
);
  localparam int SW = $bits(st_entry_t);

  word_t pc_q      [N_THREADS];
  word_t exp_pc_q  [N_THREADS];
  word_t rm0_q     [N_THREADS];
  word_t rm1_q     [N_THREADS];
  word_t retired_q [N_THREADS];
  logic [N_THREADS-1:0] mode_q;

  logic        in_order, exc, replay, commit, jump_taken;
  logic        stq_full;
  logic [$clog2(STQ_DEPTH):0] stq_count;
  st_entry_t   stq_in, stq_head;
  word_t       next_pc;

  // Packet classification; first matching case wins.
  assign in_order   = (wb_pc == exp_pc_q[wb_thread]);
  assign exc        = in_order & (wb_itlb_miss | wb_dtlb_miss);
  assign replay     = in_order & ~exc & (~wb_isvalid | (wb_flag_store & stq_full));
  assign commit     = in_order & ~exc & ~replay;
  assign jump_taken = wb_flag_jump & (~wb_flag_branch | wb_isequal);

  // iret outranks a jump carried in the same packet.
  always_comb begin
    next_pc = wb_pc + 32'd4;
    if (wb_flag_iret)    next_pc = rm0_q[wb_thread];
    else if (jump_taken) next_pc = wb_data;
  end

  assign stq_in = '{addr: wb_data[19:0], data: wb_r2, isbyte: wb_flag_isbyte};

  store_queue #(.DEPTH(STQ_DEPTH), .W(SW)) u_stq (
    .clk       (clk),
    .rst       (rst),
    .enq_en    (commit & wb_flag_store),
    .enq_data  (stq_in),
    .deq_ready (st_ready),
    .deq_data  (stq_head),
    .full      (stq_full),
    .count     (stq_count)
  );

  assign st_valid  = (stq_count != '0);
  assign st_addr   = stq_head.addr;
  assign st_data   = stq_head.data;
  assign st_isbyte = stq_head.isbyte;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int t = 0; t < N_THREADS; t++) begin
        pc_q[t]      <= PC_RESET;
        exp_pc_q[t]  <= PC_RESET;
        rm0_q[t]     <= '0;
        rm1_q[t]     <= '0;
        retired_q[t] <= '0;
      end
      mode_q     <= '1;
      rf_wen     <= 1'b0;
      rf_thread  <= '0;
      rf_addr    <= '0;
      rf_data    <= '0;
      itlb_wen   <= 1'b0;
      dtlb_wen   <= 1'b0;
      tlb_vpn    <= '0;
      tlb_ppn    <= '0;
      exc_en     <= 1'b0;
      exc_thread <= '0;
    end else begin
      rf_wen   <= commit & wb_flag_reg;
      itlb_wen <= commit & (wb_flag_tlbwrite == TLBW_ITLB);
      dtlb_wen <= commit & (wb_flag_tlbwrite == TLBW_DTLB);
      exc_en   <= exc;

      if (commit & wb_flag_reg) begin
        rf_thread <= wb_thread;
        rf_addr   <= wb_dst;
        rf_data   <= wb_flag_mul ? wb_mul : wb_data;
      end
      if (commit & (wb_flag_tlbwrite != TLBW_NONE)) begin
        tlb_vpn <= wb_data[19:0];
        tlb_ppn <= wb_r2[7:0];
      end

      if (exc) begin
        exc_thread           <= wb_thread;
        rm0_q[wb_thread]     <= wb_pc;
        rm1_q[wb_thread]     <= wb_dtlb_miss ? wb_data : wb_pc;
        mode_q[wb_thread]    <= 1'b1;
        pc_q[wb_thread]      <= EXC_VECTOR;
        exp_pc_q[wb_thread]  <= EXC_VECTOR;
      end else if (replay) begin
        pc_q[wb_thread]      <= exp_pc_q[wb_thread];
      end else if (commit) begin
        pc_q[wb_thread]      <= next_pc;
        exp_pc_q[wb_thread]  <= next_pc;
        retired_q[wb_thread] <= retired_q[wb_thread] + 32'd1;
        if (wb_flag_iret) mode_q[wb_thread] <= 1'b0;
      end
    end
  end

  always_comb begin
    for (int t = 0; t < N_THREADS; t++) begin
      pc[t]      = pc_q[t];
      retired[t] = retired_q[t];
    end
  end
  assign mode = mode_q;
endmodule
